// File: rtl/mshr_mem_responder.sv
// ---------------------------------------------------------------------------
// mshr_mem_responder
//
// Main-memory model sitting behind the MSHR. Load (refill) and evict
// (write-back) requests are buffered in a small in-order queue and serviced
// one at a time with a fixed access latency. Every accepted request produces
// exactly one tagged completion pulse.
//
// Optional feature (compile-time macro MEM_OOR_CHECK_EN):
//   defined   : byte addresses >= DEPTH_WORDS*4 are out of range; such writes
//               are dropped, such reads return 32'hDEADBEEF, and resp_err is
//               raised on that completion.
//   undefined : the word index wraps modulo DEPTH_WORDS; resp_err is always 0.
//
// Ports
//   clk        in   1     clock
//   rst        in   1     synchronous reset, active-low
//   req_valid  in   1     request present
//   req_ready  out  1     queue can accept (transfer on valid && ready)
//   req_we     in   1     1 = evict/write, 0 = load/read
//   req_addr   in   32    byte address, bits [1:0] ignored
//   req_wdata  in   32    write data
//   req_id     in   IDW   tag echoed on the completion
//   resp_valid out  1     one-cycle completion pulse
//   resp_id    out  IDW   tag of the completed request
//   resp_data  out  32    read data, 0 for writes
//   resp_err   out  1     out-of-range flag
// ---------------------------------------------------------------------------
module mshr_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4,
  parameter int QDEPTH      = 4,
  parameter int IDW         = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic [31:0]    req_addr,
  input  logic [31:0]    req_wdata,
  input  logic [IDW-1:0] req_id,
  output logic           resp_valid,
  output logic [IDW-1:0] resp_id,
  output logic [31:0]    resp_data,
  output logic           resp_err
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int QAW = $clog2(QDEPTH);
  localparam int CW  = $clog2(LATENCY);

  typedef struct packed {
    logic           we;
    logic [31:0]    addr;
    logic [31:0]    wdata;
    logic [IDW-1:0] id;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // -------------------------------------------------------------------------
  // Request queue
  // -------------------------------------------------------------------------
  req_t             fifo [QDEPTH];
  logic [QAW-1:0]   head;
  logic [QAW-1:0]   tail;
  logic [QAW:0]     count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (count == (QAW+1)'(QDEPTH));
  assign empty = (count == '0);

  // Readiness comes from registered occupancy only, so a pop on the same
  // edge never lets a full queue accept. Held low for the whole reset cycle.
  assign req_ready = rst && !full;
  assign push      = req_valid && req_ready;

  // NOTE: storage arrays carry no reset; occupancy and pointers alone decide
  // which entries are live, and clearing RAM would cost a write port per word.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo[tail] <= '{we: req_we, addr: req_addr, wdata: req_wdata, id: req_id};
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Service FSM
  // -------------------------------------------------------------------------
  state_t          state;
  state_t          state_d;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_d;
  req_t            cur;
  logic            access;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cnt_d   = CW'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // Back-to-back service: the next head is popped while the current
        // completion is on the bus, giving one request per LATENCY+1 cycles.
        if (!empty) begin
          pop     = 1'b1;
          cnt_d   = CW'(LATENCY - 1);
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The request in service is copied out of the queue when popped so the
  // queue slot can be refilled while the access is still pending.
  always_ff @(posedge clk) begin
    if (pop) begin
      cur <= fifo[head];
    end
  end

  // The array is touched exactly on the WAIT->RESP edge.
  assign access = (state == S_WAIT) && (cnt == '0);

  // -------------------------------------------------------------------------
  // Backing store and response registers
  // -------------------------------------------------------------------------
  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] cur_idx;
  logic          cur_oor;
  logic          unused_addr_bits;

  assign cur_idx = cur.addr[AW+1:2];

  // Byte-offset bits never select anything, and in the wrapping build the
  // bits above the index are intentionally ignored.
  assign unused_addr_bits = ^{cur.addr[31:AW+2], cur.addr[1:0]};

`ifdef MEM_OOR_CHECK_EN
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;
  assign cur_oor = ({1'b0, cur.addr} >= MEM_BYTES);
`else
  assign cur_oor = 1'b0;
`endif

  // A reset on the access edge suppresses the commit, so a write that never
  // reached RESP leaves the array untouched.
  always_ff @(posedge clk) begin
    if (rst && access && cur.we && !cur_oor) begin
      mem[cur_idx] <= cur.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_id   <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else if (access) begin
      resp_id  <= cur.id;
      resp_err <= cur_oor;
      if (cur.we) begin
        resp_data <= '0;
      end else if (cur_oor) begin
        resp_data <= 32'hDEAD_BEEF;
      end else begin
        resp_data <= mem[cur_idx];
      end
    end
  end

  assign resp_valid = (state == S_RESP);

endmodule

// File: tb/tb_mshr_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mshr_mem_responder
//
// Directed bench for mshr_mem_responder with default parameters
// (DEPTH_WORDS=1024, LATENCY=4, QDEPTH=4, IDW=2). A per-cycle vector table
// covers the isolated-request latency; hand-written sequences cover reset,
// queue-full back-pressure, ordering, reset mid-operation and out-of-range
// addressing (expectations follow MEM_OOR_CHECK_EN).
// ---------------------------------------------------------------------------
module tb_mshr_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_id;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [31:0] resp_data;
  logic        resp_err;

  mshr_mem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY    (4),
    .QDEPTH     (4),
    .IDW        (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_id    (req_id),
    .resp_valid(resp_valid),
    .resp_id   (resp_id),
    .resp_data (resp_data),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc equals the number of posedges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } rsp_t;

  rsp_t resp_q[$];

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      resp_q.push_back('{id: resp_id, data: resp_data, err: resp_err, cyc: cyc});
    end
  end

  typedef struct {
    logic        vld;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  id;
    logic        exp_ready;
    logic        exp_rv;
    logic [1:0]  exp_id;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_id    = '0;
  endtask

  // Called at a negedge; returns (at a negedge) the number of the edge on
  // which the request was accepted.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] id, output int acc);
    int n;
    n         = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_id    = id;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    acc = cyc;
    idle_inputs();
  endtask

  task automatic wait_resps(input int n, input int budget);
    int k;
    k = 0;
    while (resp_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("resp_count", 64'(resp_q.size()), 64'(n));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc[6];
    int a;
    logic [1:0]  ids[6];
    int          off[6];
    logic [31:0] od[4];
    logic [31:0] oor_data;
    logic        oor_err;

    ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    off = '{0, 1, 2, 3, 4, 7};
    od  = '{32'h0, 32'h7, 32'h0, 32'h9};

    // Isolated write then read, one row per clock; outputs are those seen
    // after the edge that consumed the row's inputs.
    tbl[0]  = '{1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 2'd1, 1'b1, 1'b0, 2'd0, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h40, 32'h0,        2'd2, 1'b1, 1'b0, 2'd0, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 1'b0, 2'd0, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 1'b0, 2'd0, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 1'b0, 2'd0, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 1'b1, 2'd1, 32'h0,        1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 1'b0, 2'd1, 32'h0,        1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 1'b0, 2'd1, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 1'b0, 2'd1, 32'h0,        1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 1'b0, 2'd1, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 1'b1, 2'd2, 32'hCAFEF00D, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 1'b0, 2'd2, 32'hCAFEF00D, 1'b0};

    // ---- Reset held with a request pending --------------------------------
    rst       = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h200;
    req_wdata = 32'h1111_1111;
    req_id    = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", {63'd0, req_ready}, 64'd0);
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    end
    idle_inputs();
    rst = 1'b1;
    #1;
    check("post_rst_ready", {63'd0, req_ready}, 64'd1);
    check("post_rst_outputs", {29'd0, resp_id, resp_data, resp_err}, 64'd0);
    repeat (10) @(negedge clk);
    check("rst_no_resp", 64'(resp_q.size()), 64'd0);

    // ---- Latency table ----------------------------------------------------
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].vld;
      req_we    = tbl[i].we;
      req_addr  = tbl[i].addr;
      req_wdata = tbl[i].wdata;
      req_id    = tbl[i].id;
      @(negedge clk);
      check($sformatf("lat_vec%0d", i),
            {27'd0, req_ready, resp_valid, resp_id, resp_data, resp_err},
            {27'd0, tbl[i].exp_ready, tbl[i].exp_rv, tbl[i].exp_id, tbl[i].exp_data, tbl[i].exp_err});
    end
    idle_inputs();
    resp_q.delete();

    // ---- Queue full: six back-to-back reads -------------------------------
    for (int i = 0; i < 6; i++) begin
      send(1'b0, 32'h40, 32'h0, ids[i], acc[i]);
    end
    for (int i = 1; i < 6; i++) begin
      check($sformatf("full_accept%0d", i), 64'(acc[i] - acc[0]), 64'(off[i]));
    end
    wait_resps(6, 60);
    for (int i = 0; i < 6 && i < resp_q.size(); i++) begin
      check($sformatf("full_resp%0d_id", i), {62'd0, resp_q[i].id}, {62'd0, ids[i]});
      check($sformatf("full_resp%0d_data", i), {32'd0, resp_q[i].data}, 64'hCAFEF00D);
      check($sformatf("full_resp%0d_time", i), 64'(resp_q[i].cyc - acc[0]), 64'(5 + 5 * i));
    end
    resp_q.delete();

    // ---- Ordering: W7, R, W9, R to the same word --------------------------
    send(1'b1, 32'h100, 32'h7, 2'd0, a);
    send(1'b0, 32'h100, 32'h0, 2'd1, a);
    send(1'b1, 32'h100, 32'h9, 2'd2, a);
    send(1'b0, 32'h100, 32'h0, 2'd3, a);
    wait_resps(4, 40);
    for (int i = 0; i < 4 && i < resp_q.size(); i++) begin
      check($sformatf("order%0d", i), {30'd0, resp_q[i].id, resp_q[i].data},
            {30'd0, 2'(i), od[i]});
    end
    resp_q.delete();

    // ---- Reset during the first WAIT --------------------------------------
    send(1'b1, 32'h300, 32'hAAAA5555, 2'd0, a);
    wait_resps(1, 20);
    resp_q.delete();
    send(1'b1, 32'h300, 32'h12345678, 2'd0, a);
    send(1'b0, 32'h300, 32'h0, 2'd1, a);
    send(1'b1, 32'h304, 32'h1, 2'd2, a);
    rst = 1'b0;
    #1;
    check("midrst_ready", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_resp", 64'(resp_q.size()), 64'd0);
    send(1'b0, 32'h300, 32'h0, 2'd3, a);
    wait_resps(1, 20);
    if (resp_q.size() > 0) begin
      check("midrst_old_value", {30'd0, resp_q[0].id, resp_q[0].data}, {30'd0, 2'd3, 32'hAAAA5555});
    end
    resp_q.delete();

    // ---- Out-of-range read ------------------------------------------------
`ifdef MEM_OOR_CHECK_EN
    oor_data = 32'hDEAD_BEEF;
    oor_err  = 1'b1;
`else
    oor_data = 32'h0BAD_F00D;
    oor_err  = 1'b0;
`endif
    send(1'b1, 32'h0, 32'h0BADF00D, 2'd1, a);
    send(1'b0, 32'h1000, 32'h0, 2'd2, a);
    wait_resps(2, 30);
    if (resp_q.size() > 1) begin
      check("oor_data", {32'd0, resp_q[1].data}, {32'd0, oor_data});
      check("oor_err", {63'd0, resp_q[1].err}, {63'd0, oor_err});
      check("oor_id", {62'd0, resp_q[1].id}, 64'd2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
